// File: rtl/tag_search_ctrl.sv
// Sequential tag-search controller: scans an ENTRIES-deep table of 6-bit tags one entry
// per cycle through a single shared equality comparator and reports the lowest matching index.

module xnor_gate_6to1 (
    input  logic [5:0] x,
    input  logic [5:0] y,
    output logic       z
);
    assign z = &(x ~^ y);
endmodule

module tag_search_ctrl #(
    parameter  int ENTRIES = 8,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [5:0]       wr_tag,
    input  logic             wr_valid,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [5:0]               key_q, key_d;
    logic                     rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0]         rsp_idx_q, rsp_idx_d;
    logic [ENTRIES-1:0][5:0]  tag_q, tag_d;
    logic [ENTRIES-1:0]       valid_q, valid_d;

    logic cmp_eq;
    logic match;

    // The one and only comparator; it always sees the pre-edge tag at the scan pointer.
    xnor_gate_6to1 u_cmp (
        .x (tag_q[idx_q]),
        .y (key_q),
        .z (cmp_eq)
    );

    assign match = valid_q[idx_q] && cmp_eq;

    // NOTE: every variable is given a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        key_d     = key_q;
        rsp_hit_d = rsp_hit_q;
        rsp_idx_d = rsp_idx_q;
        tag_d     = tag_q;
        valid_d   = valid_q;

        if (wr_en) begin
            tag_d[wr_idx]   = wr_tag;
            valid_d[wr_idx] = wr_valid;
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    key_d   = req_key;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (match) begin
                    rsp_hit_d = 1'b1;
                    rsp_idx_d = idx_q;
                    state_d   = RESP;
                end else if (idx_q == LAST_IDX) begin
                    rsp_hit_d = 1'b0;
                    rsp_idx_d = '0;
                    state_d   = RESP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the tag table sits in resettable flops because a reset must leave it cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            key_q     <= '0;
            rsp_hit_q <= 1'b0;
            rsp_idx_q <= '0;
            tag_q     <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            rsp_hit_q <= rsp_hit_d;
            rsp_idx_q <= rsp_idx_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_hit   = rsp_hit_q;
    assign rsp_idx   = rsp_idx_q;

endmodule
